// File: rtl/video_pixel_gather_if.sv
// Bus bundle for video_pixel_gather: feature-memory read port plus the outgoing
// pixel stream.
interface video_pixel_gather_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [15:0]       mem_rd_data;
    logic              video_valid;
    logic [47:0]       video_data;
    logic              video_ready;

    modport master (
        output mem_rd_en, mem_rd_addr, video_valid, video_data,
        input  mem_rd_data, video_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, video_valid, video_data,
        output mem_rd_data, video_ready
    );
endinterface

// File: rtl/video_pixel_gather.sv
// Planar 3-channel frame reader: gathers ch0/ch1/ch2 words per pixel into a 48-bit stream.
// Optional build macro VIDEO_GATHER_RELU_EN clamps negative channels to zero at FIFO write.
module video_pixel_gather #(
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] plane_stride,
    input  logic [9:0]        video_col_size,
    input  logic [9:0]        video_row_size,
    output logic              busy,
    output logic              done,
    output logic              video_output_req,
    video_pixel_gather_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] stride_q, pix_addr_q, rd_addr_q;
    logic [9:0]        cols_q, rows_q, col_q, row_q;
    logic [1:0]        ch_q;
    logic [CNT_W-1:0]  reserved_q;
    logic              issue, start_ok, frame_go, pix_start, pop, last_col, last_row;

    logic [2:0]        tag_q [RD_LATENCY];
    logic [15:0]       hold0_q, hold1_q;
    logic [47:0]       fifo_mem [FIFO_DEPTH];
    logic [CNT_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_wr;
    logic [47:0]       wr_word;

    assign start_ok  = (state_q == IDLE) && start;
    assign frame_go  = start_ok && (video_col_size != 10'd0) && (video_row_size != 10'd0);
    assign last_col  = (col_q == cols_q - 10'd1);
    assign last_row  = (row_q == rows_q - 10'd1);
    assign pix_start = issue && (ch_q == 2'd0);

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Reads are held back during the frame-start pulse so it always leads the first read.
    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) state_d = frame_go ? ISSUE : FIN;
            end
            ISSUE: begin
                issue = !video_output_req && ((ch_q != 2'd0) || (reserved_q < DEPTH_C));
                if (issue && (ch_q == 2'd2) && last_col && last_row) state_d = DRAIN;
            end
            DRAIN: if (reserved_q == '0) state_d = FIN;
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address walks incrementally: ch0 -> +stride -> +stride, then back to next pixel's ch0.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            video_output_req <= 1'b0;
            stride_q   <= '0;
            pix_addr_q <= '0;
            rd_addr_q  <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
        end else begin
            video_output_req <= frame_go;
            if (start_ok) begin
                stride_q   <= plane_stride;
                cols_q     <= video_col_size;
                rows_q     <= video_row_size;
                pix_addr_q <= base_addr;
                rd_addr_q  <= base_addr;
                col_q      <= '0;
                row_q      <= '0;
                ch_q       <= '0;
            end else if (issue) begin
                if (ch_q == 2'd2) begin
                    pix_addr_q <= pix_addr_q + ADDR_W'(1);
                    rd_addr_q  <= pix_addr_q + ADDR_W'(1);
                    ch_q       <= '0;
                    if (last_col) begin
                        col_q <= '0;
                        row_q <= row_q + 10'd1;
                    end else begin
                        col_q <= col_q + 10'd1;
                    end
                end else begin
                    rd_addr_q <= rd_addr_q + stride_q;
                    ch_q      <= ch_q + 2'd1;
                end
            end
        end
    end

    // Pixels reserved from first read until popped; bounds in-flight + FIFO occupancy.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            reserved_q <= '0;
        end else begin
            unique case ({pix_start, pop})
                2'b10:   reserved_q <= reserved_q + CNT_W'(1);
                2'b01:   reserved_q <= reserved_q - CNT_W'(1);
                default: reserved_q <= reserved_q;
            endcase
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            tag_q[0] <= {issue, ch_q};
            for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            if (tag_q[RD_LATENCY-1][2] && (tag_q[RD_LATENCY-1][1:0] == 2'd0)) hold0_q <= bus.mem_rd_data;
            if (tag_q[RD_LATENCY-1][2] && (tag_q[RD_LATENCY-1][1:0] == 2'd1)) hold1_q <= bus.mem_rd_data;
        end
    end

    assign fifo_wr = tag_q[RD_LATENCY-1][2] && (tag_q[RD_LATENCY-1][1:0] == 2'd2);

`ifdef VIDEO_GATHER_RELU_EN
    function automatic logic [15:0] relu16(input logic [15:0] v);
        return v[15] ? 16'h0000 : v;
    endfunction
    assign wr_word = {relu16(bus.mem_rd_data), relu16(hold1_q), relu16(hold0_q)};
`else
    assign wr_word = {bus.mem_rd_data, hold1_q, hold0_q};
`endif

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_wr) begin
                fifo_mem[wr_ptr_q[PTR_W-1:0]] <= wr_word;
                wr_ptr_q <= wr_ptr_q + CNT_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + CNT_W'(1);
        end
    end

    assign fifo_empty      = (wr_ptr_q == rd_ptr_q);
    assign pop             = !fifo_empty && bus.video_ready;
    assign bus.video_valid = pop;
    assign bus.video_data  = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = issue ? rd_addr_q : '0;
endmodule

// File: tb/tb_video_pixel_gather.sv
// Directed bench for video_pixel_gather: 2-cycle feature-memory model, stream and
// read-address logging, immediate-assertion checks against hand-computed values.
module tb_video_pixel_gather;
    logic        system_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] plane_stride = '0;
    logic [9:0]  video_col_size = '0;
    logic [9:0]  video_row_size = '0;
    logic        busy, done, video_output_req;

    video_pixel_gather_if #(.ADDR_W(16)) bus();

    video_pixel_gather #(.ADDR_W(16), .RD_LATENCY(2), .FIFO_DEPTH(8)) dut (
        .system_clk       (system_clk),
        .rst_n            (rst_n),
        .start            (start),
        .base_addr        (base_addr),
        .plane_stride     (plane_stride),
        .video_col_size   (video_col_size),
        .video_row_size   (video_row_size),
        .busy             (busy),
        .done             (done),
        .video_output_req (video_output_req),
        .bus              (bus)
    );

    always #5 system_clk = ~system_clk;

    logic [15:0] fmem [0:65535];
    logic [15:0] d1, d2;
    always @(posedge system_clk) begin
        d1 <= fmem[bus.mem_rd_addr];
        d2 <= d1;
    end
    assign bus.mem_rd_data = d2;

    int tests = 0, fails = 0;
    int cyc = 0, done_cnt = 0, req_cnt = 0, busy_cnt = 0, last_valid_cyc = 0, done_cyc = 0;
    logic [15:0] rd_q [$];
    logic [47:0] px_q [$];

    always @(posedge system_clk) cyc <= cyc + 1;

    always @(negedge system_clk) begin
        if (rst_n) begin
            if (bus.mem_rd_en) rd_q.push_back(bus.mem_rd_addr);
            if (bus.video_valid) begin
                px_q.push_back(bus.video_data);
                last_valid_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (video_output_req) req_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] r16(input logic [15:0] v);
`ifdef VIDEO_GATHER_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] exp_addr(input logic [15:0] b, input logic [15:0] s, input int c, input int p);
        return 16'(int'(b) + c * int'(s) + p);
    endfunction

    function automatic logic [47:0] exp_px(input logic [15:0] b, input logic [15:0] s, input int p);
        return {r16(fmem[exp_addr(b, s, 2, p)]), r16(fmem[exp_addr(b, s, 1, p)]), r16(fmem[exp_addr(b, s, 0, p)])};
    endfunction

    task automatic clear_logs();
        rd_q.delete();
        px_q.delete();
        done_cnt = 0;
        req_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] s, input logic [9:0] c, input logic [9:0] r);
        @(negedge system_clk);
        base_addr = b;
        plane_stride = s;
        video_col_size = c;
        video_row_size = r;
        start = 1'b1;
        @(posedge system_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge system_clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) @(posedge system_clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] b, input logic [15:0] s, input int cols, input int rows);
        int n = cols * rows;
        check({tag, "_nreads"}, 64'(rd_q.size()), 64'(3 * n));
        check({tag, "_npix"}, 64'(px_q.size()), 64'(n));
        if (rd_q.size() == 3 * n)
            for (int p = 0; p < n; p++)
                for (int c = 0; c < 3; c++)
                    check({tag, "_addr"}, 64'(rd_q[3 * p + c]), 64'(exp_addr(b, s, c, p)));
        if (px_q.size() == n)
            for (int p = 0; p < n; p++)
                check({tag, "_pix"}, 64'(px_q[p]), 64'(exp_px(b, s, p)));
    endtask

    initial begin
        logic [47:0] t2_exp;
        int n;
        for (int i = 0; i < 65536; i++) fmem[i] = 16'(i * 37 + 16'h8123);
        fmem[16'h0100] = 16'h0005;
        fmem[16'h0140] = 16'hFFFE;
        fmem[16'h0180] = 16'h0010;
        bus.video_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge system_clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_req", 64'(video_output_req), 64'd0);
        check("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("rst_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
        check("rst_valid", 64'(bus.video_valid), 64'd0);
        check("rst_data", 64'(bus.video_data), 64'd0);
        @(negedge system_clk);
        rst_n = 1'b1;

        // 2x1 frame with known data
        clear_logs();
        pulse_start(16'h0100, 16'h0040, 10'd2, 10'd1);
        check("t2_req_after_start", 64'(video_output_req), 64'd1);
        check("t2_no_read_with_req", 64'(bus.mem_rd_en), 64'd0);
        check("t2_busy", 64'(busy), 64'd1);
        wait_done("t2", 100);
        check_frame("t2", 16'h0100, 16'h0040, 2, 1);
`ifdef VIDEO_GATHER_RELU_EN
        t2_exp = 48'h0010_0000_0005;
`else
        t2_exp = 48'h0010_FFFE_0005;
`endif
        check("t2_pix0_const", 64'(px_q.size() > 0 ? px_q[0] : 48'h0), 64'(t2_exp));
        check("t2_done_once", 64'(done_cnt), 64'd1);
        check("t2_req_once", 64'(video_output_req == 1'b0 && req_cnt == 1), 64'd1);
        check("t2_valid_before_done", 64'(last_valid_cyc < done_cyc), 64'd1);
        check("t2_busy_after", 64'(busy), 64'd0);

        // Zero-size frame
        clear_logs();
        pulse_start(16'h0200, 16'h0010, 10'd0, 10'd5);
        check("t3_done", 64'(done), 64'd1);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_req", 64'(video_output_req), 64'd0);
        check("t3_rd_en", 64'(bus.mem_rd_en), 64'd0);
        @(posedge system_clk);
        #1;
        check("t3_busy_drop", 64'(busy), 64'd0);
        check("t3_done_drop", 64'(done), 64'd0);
        repeat (3) @(posedge system_clk);
        check("t3_nreads", 64'(rd_q.size()), 64'd0);
        check("t3_req_cnt", 64'(req_cnt), 64'd0);
        check("t3_busy_cycles", 64'(busy_cnt), 64'd1);
        check("t3_done_cnt", 64'(done_cnt), 64'd1);

        // Address wrap
        clear_logs();
        pulse_start(16'hFFFF, 16'h0000, 10'd2, 10'd1);
        wait_done("t4", 100);
        check("t4_addr0", 64'(rd_q.size() > 0 ? rd_q[0] : 16'h1234), 64'h0000_FFFF);
        check("t4_addr3", 64'(rd_q.size() > 3 ? rd_q[3] : 16'h1234), 64'h0000_0000);
        check_frame("t4", 16'hFFFF, 16'h0000, 2, 1);

        // Backpressure: credit limit of 8 pixels
        clear_logs();
        bus.video_ready = 1'b0;
        pulse_start(16'h0200, 16'h0100, 10'd4, 10'd4);
        repeat (200) @(posedge system_clk);
        #1;
        check("t5_reads_stalled", 64'(rd_q.size()), 64'd24);
        check("t5_no_valid", 64'(px_q.size()), 64'd0);
        check("t5_no_done", 64'(done_cnt), 64'd0);
        check("t5_still_busy", 64'(busy), 64'd1);
        @(negedge system_clk);
        bus.video_ready = 1'b1;
        wait_done("t5", 500);
        check_frame("t5", 16'h0200, 16'h0100, 4, 4);
        check("t5_done_once", 64'(done_cnt), 64'd1);

        // Reset mid-frame, then a clean frame with an ignored second start
        clear_logs();
        pulse_start(16'h0300, 16'h0010, 10'd4, 10'd2);
        n = 0;
        while (px_q.size() < 5 && n < 200) begin
            @(posedge system_clk);
            n++;
        end
        check("t6_five_pix", 64'(px_q.size() >= 5), 64'd1);
        @(negedge system_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_req", 64'(video_output_req), 64'd0);
        check("t6_rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("t6_rst_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
        check("t6_rst_valid", 64'(bus.video_valid), 64'd0);
        check("t6_rst_data", 64'(bus.video_data), 64'd0);
        @(negedge system_clk);
        rst_n = 1'b1;
        clear_logs();
        pulse_start(16'h0400, 16'h0020, 10'd3, 10'd1);
        repeat (4) @(posedge system_clk);
        #1;
        check("t6_busy_before_restart", 64'(busy), 64'd1);
        pulse_start(16'h0500, 16'h0030, 10'd7, 10'd2);
        wait_done("t6", 200);
        check_frame("t6", 16'h0400, 16'h0020, 3, 1);
        check("t6_done_once", 64'(done_cnt), 64'd1);
        check("t6_req_once", 64'(req_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
